// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: opcodes, branch encodings,
// field widths and the decoder control bundle carried down the pipe.
package mips_pkg;

  localparam int REGW   = 5;
  localparam int OPW    = 6;
  localparam int FUNW   = 6;
  localparam int ALUOPW = 3;
  localparam int BRW    = 2;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;

  localparam logic [BRW-1:0] BR_NONE = 2'b00;
  localparam logic [BRW-1:0] BR_BEQ  = 2'b01;
  localparam logic [BRW-1:0] BR_BNE  = 2'b10;

  // Decoder control bundle as stored in ID/EX.
  typedef struct packed {
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              jump;
    logic [ALUOPW-1:0] alu_op;
    logic [BRW-1:0]    branch;
  } ctrl_t;

  // An unsupported opcode leaves decoder outputs unknown; store them as 0
  // so a garbage instruction can never write state downstream.
  function automatic ctrl_t clean_ctrl(input ctrl_t c);
    logic [$bits(ctrl_t)-1:0] raw;
    logic [$bits(ctrl_t)-1:0] res;
    raw = c;
    res = '0;
    for (int i = 0; i < $bits(ctrl_t); i++) begin
      res[i] = (raw[i] === 1'b1);
    end
    return ctrl_t'(res);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write.
module load_use_detect
  import mips_pkg::*;
(
  input  logic [OPW-1:0]  id_op,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ex_valid,
  input  logic            ex_MemRead,
  input  logic [REGW-1:0] ex_rt,
  output logic            lu
);

  logic uses_rs;
  logic uses_rt;

  // Decide which source fields the ID instruction really reads, then match.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    lu      = 1'b0;
    uses_rs = (id_op != OP_J);
    uses_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) ||
              (id_op == OP_BEQ)   || (id_op == OP_BNE);
    if (ex_valid && ex_MemRead && (ex_rt != '0)) begin
      lu = (uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt));
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, external
// hold and a saturating bubble counter for performance debug.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    id_op,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Jump,
  input  logic [ALUOPW-1:0] id_ALUOp,
  input  logic [BRW-1:0]    id_Branch,
  input  logic [DW-1:0]     id_pc4,
  input  logic [DW-1:0]     id_rd1,
  input  logic [DW-1:0]     id_rd2,
  input  logic [DW-1:0]     id_imm,
  input  logic [REGW-1:0]   id_rs,
  input  logic [REGW-1:0]   id_rt,
  input  logic [REGW-1:0]   id_rd,
  input  logic [FUNW-1:0]   id_funct,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Jump,
  output logic [ALUOPW-1:0] ex_ALUOp,
  output logic [BRW-1:0]    ex_Branch,
  output logic [DW-1:0]     ex_pc4,
  output logic [DW-1:0]     ex_rd1,
  output logic [DW-1:0]     ex_rd2,
  output logic [DW-1:0]     ex_imm,
  output logic [REGW-1:0]   ex_rs,
  output logic [REGW-1:0]   ex_rt,
  output logic [REGW-1:0]   ex_rd,
  output logic [FUNW-1:0]   ex_funct,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNTW-1:0]   bubble_cnt
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic              valid;
    logic [DW-1:0]     pc4;
    logic [DW-1:0]     rd1;
    logic [DW-1:0]     rd2;
    logic [DW-1:0]     imm;
    logic [REGW-1:0]   rs;
    logic [REGW-1:0]   rt;
    logic [REGW-1:0]   rd;
    logic [FUNW-1:0]   funct;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  ctrl_t  id_ctrl;
  logic   lu;

  load_use_detect u_load_use_detect (
    .id_op      (id_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (stage_q.valid),
    .ex_MemRead (stage_q.ctrl.mem_read),
    .ex_rt      (stage_q.rt),
    .lu         (lu)
  );

  // Stall upstream while a load-use bubble is pending or the pipe is frozen.
  assign pc_write   = ~(lu | hold);
  assign ifid_write = ~(lu | hold);

  // Assemble the value captured on a normal load, with control sanitised.
  always_comb begin
    id_ctrl = '{reg_dst: id_RegDst, alu_src: id_ALUSrc, mem_to_reg: id_MemtoReg,
                reg_write: id_RegWrite, mem_read: id_MemRead,
                mem_write: id_MemWrite, jump: id_Jump, alu_op: id_ALUOp,
                branch: id_Branch};
    stage_d       = '0;
    stage_d.ctrl  = clean_ctrl(id_ctrl);
    stage_d.valid = 1'b1;
    stage_d.pc4   = id_pc4;
    stage_d.rd1   = id_rd1;
    stage_d.rd2   = id_rd2;
    stage_d.imm   = id_imm;
    stage_d.rs    = id_rs;
    stage_d.rt    = id_rt;
    stage_d.rd    = id_rd;
    stage_d.funct = id_funct;
  end

  // Pipeline register: reset/flush clear, hold freezes, load-use inserts a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || flush) begin
      stage_q <= '0;
    end else if (!hold) begin
      stage_q <= lu ? '0 : stage_d;
    end
  end

  // Saturating bubble counter; only real inserted bubbles count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!flush && !hold && lu && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNTW'(1);
    end
  end

  assign ex_RegDst   = stage_q.ctrl.reg_dst;
  assign ex_ALUSrc   = stage_q.ctrl.alu_src;
  assign ex_MemtoReg = stage_q.ctrl.mem_to_reg;
  assign ex_RegWrite = stage_q.ctrl.reg_write;
  assign ex_MemRead  = stage_q.ctrl.mem_read;
  assign ex_MemWrite = stage_q.ctrl.mem_write;
  assign ex_Jump     = stage_q.ctrl.jump;
  assign ex_ALUOp    = stage_q.ctrl.alu_op;
  assign ex_Branch   = stage_q.ctrl.branch;
  assign ex_valid    = stage_q.valid;
  assign ex_pc4      = stage_q.pc4;
  assign ex_rd1      = stage_q.rd1;
  assign ex_rd2      = stage_q.rd2;
  assign ex_imm      = stage_q.imm;
  assign ex_rs       = stage_q.rs;
  assign ex_rt       = stage_q.rt;
  assign ex_rd       = stage_q.rd;
  assign ex_funct    = stage_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNTW=4 build so saturation is reachable).
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW   = 32;
  localparam int CNTW = 4;

  // Control concatenation order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Jump ALUOp[2:0] Branch[1:0]
  localparam logic [11:0] CTRL_NONE = 12'b0000000_000_00;
  localparam logic [11:0] CTRL_ADD  = 12'b1001000_110_00;
  localparam logic [11:0] CTRL_LW   = 12'b0111100_000_00;
  localparam logic [11:0] CTRL_BEQ  = 12'b0000000_001_01;
  localparam logic [11:0] CTRL_ORI  = 12'b0101000_011_00;

  logic              clk = 1'b0;
  logic              rst;
  logic [OPW-1:0]    id_op;
  logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic              id_MemRead, id_MemWrite, id_Jump;
  logic [ALUOPW-1:0] id_ALUOp;
  logic [BRW-1:0]    id_Branch;
  logic [DW-1:0]     id_pc4, id_rd1, id_rd2, id_imm;
  logic [REGW-1:0]   id_rs, id_rt, id_rd;
  logic [FUNW-1:0]   id_funct;
  logic              flush, hold;
  logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
  logic              ex_MemRead, ex_MemWrite, ex_Jump;
  logic [ALUOPW-1:0] ex_ALUOp;
  logic [BRW-1:0]    ex_Branch;
  logic [DW-1:0]     ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REGW-1:0]   ex_rs, ex_rt, ex_rd;
  logic [FUNW-1:0]   ex_funct;
  logic              ex_valid, pc_write, ifid_write;
  logic [CNTW-1:0]   bubble_cnt;
  logic [11:0]       ex_ctrl;

  int                vectors    = 0;
  int                miscompares = 0;
  logic [CNTW-1:0]   exp_cnt;
  logic [DW-1:0]     pc_ctr;

  assign ex_ctrl = {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                    ex_MemWrite, ex_Jump, ex_ALUOp, ex_Branch};

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_op(id_op),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_Jump(id_Jump), .id_ALUOp(id_ALUOp), .id_Branch(id_Branch),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .hold(hold),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp), .ex_Branch(ex_Branch),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write),
    .bubble_cnt(bubble_cnt)
  );

  // Advance one clock; return 1ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID with the decoder controls it would produce.
  task automatic drive(input logic [OPW-1:0] op, input logic [REGW-1:0] rs,
                       input logic [REGW-1:0] rt, input logic [REGW-1:0] rd,
                       input logic [DW-1:0] imm, input logic [DW-1:0] rd1,
                       input logic [DW-1:0] rd2);
    {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
     id_Jump, id_ALUOp, id_Branch} = CTRL_NONE;
    case (op)
      OP_RTYPE: begin id_RegDst = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 3'b110; end
      OP_LW:    begin id_ALUSrc = 1'b1; id_MemtoReg = 1'b1; id_RegWrite = 1'b1; id_MemRead = 1'b1; end
      OP_SW:    begin id_ALUSrc = 1'b1; id_MemWrite = 1'b1; end
      OP_BEQ:   begin id_ALUOp = 3'b001; id_Branch = BR_BEQ; end
      OP_BNE:   begin id_ALUOp = 3'b001; id_Branch = BR_BNE; end
      OP_ADDI:  begin id_ALUSrc = 1'b1; id_RegWrite = 1'b1; end
      OP_ANDI:  begin id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 3'b010; end
      OP_ORI:   begin id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 3'b011; end
      OP_XORI:  begin id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 3'b100; end
      OP_SLTI:  begin id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 3'b101; end
      OP_J:     begin id_Jump = 1'b1; end
      default:  ;
    endcase
    if (id_Branch == BR_NONE && op == OP_BEQ) id_Branch = BR_BEQ;
    id_op    = op;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
    id_imm   = imm;
    id_rd1   = rd1;
    id_rd2   = rd2;
    id_funct = (op == OP_RTYPE) ? 6'h20 : imm[5:0];
    pc_ctr   = pc_ctr + 32'd4;
    id_pc4   = pc_ctr;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    drive(OP_RTYPE, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    vectors++; if (ex_ctrl !== CTRL_NONE) begin miscompares++; $display("FAIL reset_ctrl: got %b want %b", ex_ctrl, CTRL_NONE); end
    vectors++; if (ex_pc4 !== 32'd0 || ex_rd1 !== 32'd0) begin miscompares++; $display("FAIL reset_data: pc4 %h rd1 %h want 0", ex_pc4, ex_rd1); end
    vectors++; if (bubble_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    vectors++; if ({pc_write, ifid_write} !== 2'b11) begin miscompares++; $display("FAIL reset_stall: got %b want 11", {pc_write, ifid_write}); end
    exp_cnt = 4'd0;
  endtask

  task automatic test_load();
    pc_ctr = 32'h100;
    drive(OP_RTYPE, 5'd1, 5'd2, 5'd3, 32'd0, 32'd5, 32'd7);  // add $3,$1,$2
    tick();
    vectors++; if (ex_ctrl !== CTRL_ADD) begin miscompares++; $display("FAIL load_ctrl: got %b want %b", ex_ctrl, CTRL_ADD); end
    vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL load_valid: got %b want 1", ex_valid); end
    vectors++; if (ex_rd1 !== 32'd5 || ex_rd2 !== 32'd7) begin miscompares++; $display("FAIL load_data: rd1 %0d rd2 %0d want 5 7", ex_rd1, ex_rd2); end
    vectors++; if ({ex_rs, ex_rt, ex_rd} !== {5'd1, 5'd2, 5'd3} || ex_funct !== 6'h20 || ex_pc4 !== 32'h104) begin
      miscompares++; $display("FAIL load_fields: rs %0d rt %0d rd %0d funct %h pc4 %h want 1 2 3 20 104", ex_rs, ex_rt, ex_rd, ex_funct, ex_pc4);
    end
  endtask

  task automatic test_load_use();
    drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'h10, 32'd0);      // lw $2,0($1)
    tick();
    drive(OP_RTYPE, 5'd2, 5'd5, 5'd4, 32'd0, 32'h11, 32'h22);  // add $4,$2,$5
    #1;
    vectors++; if ({pc_write, ifid_write} !== 2'b00) begin miscompares++; $display("FAIL lu_stall: got %b want 00", {pc_write, ifid_write}); end
    tick();
    exp_cnt = 4'd1;
    vectors++; if (ex_ctrl !== CTRL_NONE || ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble: ctrl %b valid %b want 0 0", ex_ctrl, ex_valid); end
    vectors++; if (ex_rd1 !== 32'd0 || ex_rt !== 5'd0) begin miscompares++; $display("FAIL lu_bubble_data: rd1 %h rt %0d want 0", ex_rd1, ex_rt); end
    vectors++; if (bubble_cnt !== exp_cnt) begin miscompares++; $display("FAIL lu_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
    vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_release: got %b want 1", pc_write); end
    tick();
    vectors++; if (ex_ctrl !== CTRL_ADD || ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_rd1 !== 32'h11) begin
      miscompares++; $display("FAIL lu_consumer: ctrl %b valid %b rd %0d rd1 %h want %b 1 4 11", ex_ctrl, ex_valid, ex_rd, ex_rd1, CTRL_ADD);
    end
  endtask

  task automatic test_no_stall_cases();
    // lw $0 in EX, ID reads $0: no hazard
    drive(OP_LW, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    drive(OP_RTYPE, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0);
    #1;
    vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_r0: pc_write %b want 1", pc_write); end
    // lw $2 in EX, addi $2,$2,1: stall through rs
    drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    drive(OP_ADDI, 5'd2, 5'd2, 5'd0, 32'd1, 32'd0, 32'd0);
    #1;
    vectors++; if (ifid_write !== 1'b0) begin miscompares++; $display("FAIL lu_rs: ifid_write %b want 0", ifid_write); end
    tick(); exp_cnt = exp_cnt + 4'd1; tick();
    // lw $2 in EX, lw $2,0($7): lw does not read rt
    drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    drive(OP_LW, 5'd7, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_lw_rt: pc_write %b want 1", pc_write); end
    tick();  // lw $2 now in EX again
    // j whose target bits alias rs/rt = $2: no hazard
    drive(OP_J, 5'd2, 5'd2, 5'd2, 32'd0, 32'd0, 32'd0);
    #1;
    vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_jump: pc_write %b want 1", pc_write); end
    // sw $2,0($8): stall through rt
    drive(OP_SW, 5'd8, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL lu_sw_rt: pc_write %b want 0", pc_write); end
    tick(); exp_cnt = exp_cnt + 4'd1; tick();
    vectors++; if (bubble_cnt !== exp_cnt) begin miscompares++; $display("FAIL lu_cases_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
  endtask

  task automatic test_flush_lu();
    drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'h33, 32'd0);
    tick();
    drive(OP_RTYPE, 5'd2, 5'd3, 5'd6, 32'd0, 32'h44, 32'h55);
    flush = 1'b1;
    #1;
    vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL flush_stall: pc_write %b want 0", pc_write); end
    tick();
    flush = 1'b0;
    vectors++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_NONE || ex_rd1 !== 32'd0) begin
      miscompares++; $display("FAIL flush_clear: valid %b ctrl %b rd1 %h want 0", ex_valid, ex_ctrl, ex_rd1);
    end
    vectors++; if (bubble_cnt !== exp_cnt) begin miscompares++; $display("FAIL flush_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_hold();
    drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'h66, 32'd0);
    tick();
    drive(OP_RTYPE, 5'd2, 5'd3, 5'd7, 32'd0, 32'h77, 32'h88);
    hold = 1'b1;
    #1;
    vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL hold_stall: pc_write %b want 0", pc_write); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ex_ctrl !== CTRL_LW || ex_valid !== 1'b1 || ex_rt !== 5'd2 || ex_rd1 !== 32'h66) begin
        miscompares++; $display("FAIL hold_frozen[%0d]: ctrl %b valid %b rt %0d rd1 %h", i, ex_ctrl, ex_valid, ex_rt, ex_rd1);
      end
      vectors++; if (bubble_cnt !== exp_cnt) begin miscompares++; $display("FAIL hold_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt); end
    end
    hold = 1'b0;
    #1;
    vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL hold_release_lu: pc_write %b want 0", pc_write); end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    vectors++; if (ex_valid !== 1'b0 || bubble_cnt !== exp_cnt) begin
      miscompares++; $display("FAIL hold_bubble: valid %b cnt %0d want 0 %0d", ex_valid, bubble_cnt, exp_cnt);
    end
    tick();
    vectors++; if (ex_rd !== 5'd7 || ex_valid !== 1'b1) begin miscompares++; $display("FAIL hold_consumer: rd %0d valid %b want 7 1", ex_rd, ex_valid); end
  endtask

  task automatic test_back_to_back();
    drive(OP_BEQ, 5'd9, 5'd10, 5'd0, 32'h8, 32'd1, 32'd2);
    tick();
    vectors++; if (ex_ctrl !== CTRL_BEQ || ex_imm !== 32'h8) begin miscompares++; $display("FAIL b2b_beq: ctrl %b imm %h want %b 8", ex_ctrl, ex_imm, CTRL_BEQ); end
    drive(OP_ORI, 5'd11, 5'd12, 5'd0, 32'hff, 32'h3, 32'd0);
    tick();
    vectors++; if (ex_ctrl !== CTRL_ORI || ex_rd1 !== 32'h3 || ex_rt !== 5'd12) begin
      miscompares++; $display("FAIL b2b_ori: ctrl %b rd1 %h rt %0d want %b 3 12", ex_ctrl, ex_rd1, ex_rt, CTRL_ORI);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0);
      tick();
      drive(OP_RTYPE, 5'd2, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0);
      tick();
      exp_cnt = (exp_cnt == 4'hf) ? 4'hf : exp_cnt + 4'd1;
      vectors++; if (bubble_cnt !== exp_cnt) begin miscompares++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt); end
    end
    vectors++; if (bubble_cnt !== 4'hf) begin miscompares++; $display("FAIL sat_final: got %0d want 15", bubble_cnt); end
  endtask

  task automatic test_rst_mid_stall();
    drive(OP_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'h99, 32'd0);
    tick();
    drive(OP_RTYPE, 5'd2, 5'd3, 5'd8, 32'd0, 32'd1, 32'd1);
    #1;
    vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL rst_pre_stall: pc_write %b want 0", pc_write); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_NONE || ex_pc4 !== 32'd0 || ex_rd1 !== 32'd0 || ex_rt !== 5'd0) begin
      miscompares++; $display("FAIL rst_stall_regs: valid %b ctrl %b pc4 %h rd1 %h rt %0d want 0", ex_valid, ex_ctrl, ex_pc4, ex_rd1, ex_rt);
    end
    vectors++; if (bubble_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_stall_cnt: got %0d want 0", bubble_cnt); end
    vectors++; if ({pc_write, ifid_write} !== 2'b11) begin miscompares++; $display("FAIL rst_stall_release: got %b want 11", {pc_write, ifid_write}); end
  endtask

  initial begin
    pc_ctr = 32'h0;
    test_reset();
    test_load();
    test_load_use();
    test_no_stall_cases();
    test_flush_lu();
    test_hold();
    test_back_to_back();
    test_saturation();
    test_rst_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
